// File: rtl/perf_counter_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : perf_counter_unit                                          |
// | Description : Run/halt performance counters with saturating 32-bit       |
// |               counts and registered read-back. Cache counters present    |
// |               only when PERF_CACHE_CNT_EN is defined.                    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module perf_counter_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic        icache_req,
    input  logic        icache_hit,
    input  logic        dcache_req,
    input  logic        dcache_hit,
    input  logic        clr,
    input  logic [2:0]  rd_sel,
    output logic [31:0] rd_data,
    output logic [1:0]  state,
    output logic        overflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_cycleCnt;
    logic [31:0] r_instCnt;
    logic [31:0] r_rdData;
    logic        r_overflow;
    logic [31:0] w_rdMux;
    logic        w_run;
    logic        w_clear;
    logic        w_incCycle;
    logic        w_incInst;
    logic        w_coreSat;
    logic        w_cacheSat;

    function automatic logic [31:0] satInc(input logic [31:0] value, input logic en);
        return (en && (value != c_CNT_MAX)) ? value + 32'd1 : value;
    endfunction

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:   if (!clr && start) w_stateNext = ST_RUN;
            ST_RUN:    if (halt)          w_stateNext = ST_HALTED;
            ST_HALTED: if (clr)           w_stateNext = ST_IDLE;
            default:                      w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    assign w_run      = (r_state == ST_RUN);
    assign w_clear    = clr && ((r_state == ST_IDLE) || (r_state == ST_HALTED));
    assign w_incCycle = w_run;
    assign w_incInst  = w_run && (halt || reg_write || mem_write);
    assign w_coreSat  = (w_incCycle && (r_cycleCnt == c_CNT_MAX)) ||
                        (w_incInst  && (r_instCnt  == c_CNT_MAX));

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_cycleCnt <= '0;
            r_instCnt  <= '0;
        end else begin
            r_cycleCnt <= satInc(r_cycleCnt, w_incCycle);
            r_instCnt  <= satInc(r_instCnt,  w_incInst);
        end
    end

`ifdef PERF_CACHE_CNT_EN
    logic [31:0] r_icReqCnt;
    logic [31:0] r_icHitCnt;
    logic [31:0] r_dcReqCnt;
    logic [31:0] r_dcHitCnt;
    logic        w_incIcReq;
    logic        w_incIcHit;
    logic        w_incDcReq;
    logic        w_incDcHit;

    // A hit strobe only counts when qualified by its own request.
    assign w_incIcReq = w_run && icache_req;
    assign w_incIcHit = w_run && icache_req && icache_hit;
    assign w_incDcReq = w_run && dcache_req;
    assign w_incDcHit = w_run && dcache_req && dcache_hit;
    assign w_cacheSat = (w_incIcReq && (r_icReqCnt == c_CNT_MAX)) ||
                        (w_incIcHit && (r_icHitCnt == c_CNT_MAX)) ||
                        (w_incDcReq && (r_dcReqCnt == c_CNT_MAX)) ||
                        (w_incDcHit && (r_dcHitCnt == c_CNT_MAX));

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_icReqCnt <= '0;
            r_icHitCnt <= '0;
            r_dcReqCnt <= '0;
            r_dcHitCnt <= '0;
        end else begin
            r_icReqCnt <= satInc(r_icReqCnt, w_incIcReq);
            r_icHitCnt <= satInc(r_icHitCnt, w_incIcHit);
            r_dcReqCnt <= satInc(r_dcReqCnt, w_incDcReq);
            r_dcHitCnt <= satInc(r_dcHitCnt, w_incDcHit);
        end
    end
`else
    logic w_unusedCache;

    assign w_unusedCache = ^{icache_req, icache_hit, dcache_req, dcache_hit};
    assign w_cacheSat    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_overflow <= 1'b0;
        end else if (w_coreSat || w_cacheSat) begin
            r_overflow <= 1'b1;
        end
    end

    // Read-back samples pre-update values, giving one cycle of latency.
    always_comb begin
        w_rdMux = '0;
        case (rd_sel)
            3'd0: w_rdMux = r_cycleCnt;
            3'd1: w_rdMux = r_instCnt;
`ifdef PERF_CACHE_CNT_EN
            3'd2: w_rdMux = r_icReqCnt;
            3'd3: w_rdMux = r_icHitCnt;
            3'd4: w_rdMux = r_dcReqCnt;
            3'd5: w_rdMux = r_dcHitCnt;
`endif
            3'd6: w_rdMux = {30'b0, r_state};
            3'd7: w_rdMux = {31'b0, r_overflow};
            default: w_rdMux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= w_rdMux;
        end
    end

    assign rd_data  = r_rdData;
    assign state    = r_state;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_perf_counter_unit                                       |
// | Description : Self-checking bench for perf_counter_unit against a        |
// |               behavioural model; honours PERF_CACHE_CNT_EN.              |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_perf_counter_unit;

`ifdef PERF_CACHE_CNT_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, halt, reg_write, mem_write;
    logic        icache_req, icache_hit, dcache_req, dcache_hit, clr;
    logic [2:0]  rd_sel;
    logic [31:0] rd_data;
    logic [1:0]  state;
    logic        overflow;

    int nChecks = 0;
    int nErrors = 0;

    logic [31:0] mCnt [6];
    logic [1:0]  mState;
    logic        mOvf;
    logic [31:0] mRd;

    always #5 clk = ~clk;

    perf_counter_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt       (halt),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .icache_req (icache_req),
        .icache_hit (icache_hit),
        .dcache_req (dcache_req),
        .dcache_hit (dcache_hit),
        .clr        (clr),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .state      (state),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [2:0] sel);
        case (sel)
            3'd0, 3'd1:             return mCnt[sel];
            3'd2, 3'd3, 3'd4, 3'd5: return CACHE_EN ? mCnt[sel] : 32'd0;
            3'd6:                   return {30'b0, mState};
            default:                return {31'b0, mOvf};
        endcase
    endfunction

    function automatic void bump(input int idx, input logic en);
        if (en) begin
            if (mCnt[idx] == 32'hFFFF_FFFF) mOvf = 1'b1;
            else                            mCnt[idx] = mCnt[idx] + 32'd1;
        end
    endfunction

    function automatic void modelClear();
        for (int i = 0; i < 6; i++) mCnt[i] = 32'd0;
        mOvf = 1'b0;
    endfunction

    // State codes: 0 idle, 1 run, 2 halted; anything else falls back to idle.
    task automatic modelEdge();
        logic [1:0] nxt;
        if (rst) begin
            modelClear();
            mState = 2'd0;
            mRd    = 32'd0;
        end else begin
            mRd = modelRead(rd_sel);
            if (mState == 2'd1) begin
                bump(0, 1'b1);
                bump(1, halt | reg_write | mem_write);
                if (CACHE_EN) begin
                    bump(2, icache_req);
                    bump(3, icache_req & icache_hit);
                    bump(4, dcache_req);
                    bump(5, dcache_req & dcache_hit);
                end
            end
            nxt = mState;
            if (mState == 2'd0)      nxt = clr ? 2'd0 : (start ? 2'd1 : 2'd0);
            else if (mState == 2'd1) nxt = halt ? 2'd2 : 2'd1;
            else if (mState == 2'd2) nxt = clr ? 2'd0 : 2'd2;
            else                     nxt = 2'd0;
            if (clr && (mState == 2'd0 || mState == 2'd2)) modelClear();
            mState = nxt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        chk("state",    {30'b0, state},    {30'b0, mState});
        chk("overflow", {31'b0, overflow}, {31'b0, mOvf});
        chk("rd_data",  rd_data,           mRd);
    endtask

    task automatic readSel(input logic [2:0] s, input string tag, input logic [31:0] exp);
        rd_sel = s;
        tick();
        chk(tag, rd_data, exp);
    endtask

    task automatic pulse(input int which);
        start = (which == 0);
        halt  = (which == 1);
        clr   = (which == 2);
        tick();
        start = 1'b0;
        halt  = 1'b0;
        clr   = 1'b0;
    endtask

    initial begin
        {rst, start, halt, reg_write, mem_write, clr} = '0;
        {icache_req, icache_hit, dcache_req, dcache_hit} = '0;
        rd_sel = 3'd0;
        modelClear();
        mState = 2'd0;
        mRd    = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_state", {30'b0, state}, 32'd0);
        chk("reset_rd", rd_data, 32'd0);

        // Ten run cycles with four writes, noisy cache strobes, then halt.
        pulse(0);
        for (int i = 0; i < 10; i++) begin
            reg_write = (i == 0 || i == 3 || i == 6 || i == 9);
            {icache_req, icache_hit, dcache_req, dcache_hit} = 4'($urandom);
            tick();
        end
        reg_write = 1'b0;
        {icache_req, icache_hit, dcache_req, dcache_hit} = '0;
        pulse(1);
        chk("basic_halted", {30'b0, state}, 32'd2);
        readSel(3'd0, "basic_cycle", 32'd11);
        readSel(3'd1, "basic_inst", 32'd5);
        for (int s = 2; s <= 5; s++)
            readSel(3'(s), "cache_sel", CACHE_EN ? mCnt[s] : 32'd0);
        pulse(2);
        chk("clr_to_idle", {30'b0, state}, 32'd0);

        // Icache: six requests, three qualified hits, two unqualified hits.
        pulse(0);
        for (int i = 0; i < 8; i++) begin
            icache_req = (i < 6);
            icache_hit = (i == 0 || i == 2 || i == 4 || i >= 6);
            tick();
        end
        {icache_req, icache_hit} = '0;
        pulse(1);
        readSel(3'd2, "icache_req", CACHE_EN ? 32'd6 : 32'd0);
        readSel(3'd3, "icache_hit", CACHE_EN ? 32'd3 : 32'd0);
        pulse(2);

        // Saturation: preload cycle count near the top.
        force dut.r_cycleCnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycleCnt;
        mCnt[0] = 32'hFFFF_FFFE;
        pulse(0);
        tick();
        tick();
        tick();
        chk("sat_overflow", {31'b0, overflow}, 32'd1);
        pulse(1);
        readSel(3'd0, "sat_cycle", 32'hFFFF_FFFF);
        readSel(3'd7, "sat_ovf_sel", 32'd1);
        pulse(2);
        chk("sat_clr_ovf", {31'b0, overflow}, 32'd0);
        readSel(3'd0, "sat_clr_cycle", 32'd0);

        // clr mid-run is ignored; start with clr in idle stays idle.
        pulse(0);
        for (int i = 0; i < 8; i++) begin
            clr  = (i == 4);
            halt = (i == 7);
            tick();
        end
        {clr, halt} = '0;
        readSel(3'd0, "midrun_clr_cycle", 32'd8);
        pulse(2);
        start = 1'b1;
        clr   = 1'b1;
        tick();
        {start, clr} = '0;
        chk("start_clr_idle", {30'b0, state}, 32'd0);

        // halt with start in idle: enter run with no count that cycle.
        start = 1'b1;
        halt  = 1'b1;
        tick();
        start = 1'b0;
        chk("start_halt_run", {30'b0, state}, 32'd1);
        tick();
        halt = 1'b0;
        readSel(3'd0, "start_halt_cycle", 32'd1);
        pulse(2);

        // Reset in the middle of a run leaves no residue.
        pulse(0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_run_state", {30'b0, state}, 32'd0);
        rd_sel = 3'd1;
        pulse(0);
        tick();
        tick();
        tick();
        pulse(1);
        readSel(3'd0, "rst_rerun_cycle", 32'd4);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            start      = ($urandom_range(0, 7) == 0);
            halt       = ($urandom_range(0, 15) == 0);
            clr        = ($urandom_range(0, 11) == 0);
            reg_write  = 1'($urandom);
            mem_write  = 1'($urandom);
            icache_req = 1'($urandom);
            icache_hit = 1'($urandom);
            dcache_req = 1'($urandom);
            dcache_hit = 1'($urandom);
            rd_sel     = 3'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
